// File: rtl/user_event_gen_pkg.sv
// Shared definitions for the keyboard-to-game event generator: event codes,
// PS/2 scan-code constants, parser states and the extended-key decoder.
package user_event_gen_pkg;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_NEW_GAME = 3'd1,
        EV_LEFT     = 3'd2,
        EV_RIGHT    = 3'd3,
        EV_DOWN     = 3'd4,
        EV_ROTATE   = 3'd5
    } user_event_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        IDLE_S,
        EXT_S,
        BREAK_S,
        EXT_BREAK_S
    } parse_state_t;

    // Arrow keys arrive as E0-prefixed codes; up-arrow maps to rotate.
    function automatic user_event_t decode_ext(input logic [7:0] sc);
        user_event_t ev;
        ev = EV_NONE;
        case (sc)
            SC_LEFT:  ev = EV_LEFT;
            SC_RIGHT: ev = EV_RIGHT;
            SC_DOWN:  ev = EV_DOWN;
            SC_UP:    ev = EV_ROTATE;
            default:  ev = EV_NONE;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/user_event_gen_if.sv
// Scan-code input and event-queue consumer port of user_event_gen.
// slave = the generator, master = keyboard receiver / game consumer side.
interface user_event_gen_if;
    import user_event_gen_pkg::*;

    logic [7:0]  scan_code_i;
    logic        scan_code_valid_i;
    user_event_t user_event_o;
    logic        user_event_ready_o;
    logic        user_event_rd_req_i;
    logic        overflow_o;

    modport master (
        output scan_code_i, scan_code_valid_i, user_event_rd_req_i,
        input  user_event_o, user_event_ready_o, overflow_o
    );

    modport slave (
        input  scan_code_i, scan_code_valid_i, user_event_rd_req_i,
        output user_event_o, user_event_ready_o, overflow_o
    );
endinterface

// File: rtl/user_event_fifo.sv
// Show-ahead event queue. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module user_event_fifo
    import user_event_gen_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_req,
    input  user_event_t wr_data,
    input  logic        rd_req,
    output user_event_t rd_data,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    user_event_t mem_q [FIFO_DEPTH];
    logic        do_rd, do_wr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd = rd_req && !empty;
    // A pop frees the slot on a full queue, so the push can proceed.
    assign do_wr = wr_req && (!full || do_rd);
    assign rd_data = empty ? EV_NONE : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are masked by empty, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/user_event_gen.sv
// PS/2 scan-code parser feeding an event queue.
// Optional held-down-arrow auto repeat: define USER_EVENT_GEN_REPEAT_EN.
module user_event_gen
    import user_event_gen_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [23:0] REPEAT_TICKS = 24'd5_000_000
) (
    input logic              clk_i,
    input logic              rst_i,
    user_event_gen_if.slave  bus
);
    parse_state_t state_q, state_d;
    user_event_t  dec_ev;
    user_event_t  push_ev_d, push_ev_q;
    user_event_t  head;
    logic         wr_req, empty, full, do_pop;
    logic         ovf_d, ovf_q;

    // Parser next state and decoded event for the current byte.
    always_comb begin
        state_d = state_q;
        dec_ev  = EV_NONE;
        if (bus.scan_code_valid_i) begin
            unique case (state_q)
                IDLE_S: begin
                    if (bus.scan_code_i == SC_EXT)        state_d = EXT_S;
                    else if (bus.scan_code_i == SC_BREAK) state_d = BREAK_S;
                    else if (bus.scan_code_i == SC_ENTER) dec_ev  = EV_NEW_GAME;
                end
                EXT_S: begin
                    if (bus.scan_code_i == SC_BREAK) state_d = EXT_BREAK_S;
                    else begin
                        state_d = IDLE_S;
                        dec_ev  = decode_ext(bus.scan_code_i);
                    end
                end
                BREAK_S:     state_d = IDLE_S;
                EXT_BREAK_S: state_d = IDLE_S;
            endcase
        end
    end

    // Parser state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE_S;
        else        state_q <= state_d;
    end

`ifdef USER_EVENT_GEN_REPEAT_EN
    localparam logic [23:0] RptLast = REPEAT_TICKS - 24'd1;

    logic        down_held_q;
    logic [23:0] rpt_cnt_q;
    logic        mk_down, br_down, rpt_fire;

    assign mk_down  = bus.scan_code_valid_i && (state_q == EXT_S) &&
                      (bus.scan_code_i == SC_DOWN);
    assign br_down  = bus.scan_code_valid_i && (state_q == EXT_BREAK_S) &&
                      (bus.scan_code_i == SC_DOWN);
    assign rpt_fire = down_held_q && !mk_down && !br_down && (rpt_cnt_q == RptLast);
    // Decoded events win over a coincident repeat; the repeat is lost.
    assign push_ev_d = (dec_ev != EV_NONE) ? dec_ev :
                       rpt_fire            ? EV_DOWN : EV_NONE;

    // Held-down tracking and repeat period counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            down_held_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else if (mk_down) begin
            down_held_q <= 1'b1;
            rpt_cnt_q   <= '0;
        end else if (br_down) begin
            down_held_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else if (rpt_fire) begin
            rpt_cnt_q   <= '0;
        end else if (down_held_q) begin
            rpt_cnt_q   <= rpt_cnt_q + 24'd1;
        end
    end
`else
    assign push_ev_d = dec_ev;
`endif

    // One-cycle decode stage in front of the queue.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) push_ev_q <= EV_NONE;
        else        push_ev_q <= push_ev_d;
    end

    assign wr_req = (push_ev_q != EV_NONE);
    assign do_pop = bus.user_event_rd_req_i && !empty;

    // Drop on full without pop sets the flag; an accepted new-game clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && full && !do_pop)           ovf_d = 1'b1;
        else if (wr_req && push_ev_q == EV_NEW_GAME) ovf_d = 1'b0;
    end

    // Sticky overflow register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    user_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_req  (wr_req),
        .wr_data (push_ev_q),
        .rd_req  (bus.user_event_rd_req_i),
        .rd_data (head),
        .empty   (empty),
        .full    (full)
    );

    assign bus.user_event_o       = head;
    assign bus.user_event_ready_o = !empty;
    assign bus.overflow_o         = ovf_q;
endmodule
